// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer: register map, CTRL
// field positions, mode codes, FSM encoding and default window base.
package bus_timer_pkg;

  localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_7F00;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_PRESET = 4'h4;
  localparam logic [3:0] OFS_COUNT  = 4'h8;

  localparam logic [1:0] IDX_CTRL   = OFS_CTRL[3:2];
  localparam logic [1:0] IDX_PRESET = OFS_PRESET[3:2];
  localparam logic [1:0] IDX_COUNT  = OFS_COUNT[3:2];

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/bus_timer.sv
// Countdown timer on the CPU data bus with one-shot / auto-reload modes,
// combinational read-back and a maskable interrupt line.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] m;
    m = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_v[8*i +: 8];
    end
    return m;
  endfunction

  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_preset;
  logic [31:0]       r_count;
  logic              r_irq_flag;
  state_t            r_state;

  state_t            w_state_next;
  logic [31:0]       w_count_next;
  logic              w_irq_next;
  logic              w_en_clr;

  logic              w_sel;
  logic [1:0]        w_idx;
  logic              w_wr;
  logic              w_ctrl_wr;
  logic              w_preset_wr;
  logic              w_en;
  logic [1:0]        w_mode;
  logic [31:0]       w_ctrl_merged;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_idx         = addr[3:2];
  assign w_wr          = w_sel && (byteen != 4'b0000);
  assign w_ctrl_wr     = w_wr && (w_idx == IDX_CTRL);
  assign w_preset_wr   = w_wr && (w_idx == IDX_PRESET);
  assign w_en          = r_ctrl[CTRL_EN];
  assign w_mode        = r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign w_ctrl_merged = lane_merge({{(32-CTRL_W){1'b0}}, r_ctrl}, wdata, byteen);
  assign w_unused      = &{1'b0, w_ctrl_merged[31:CTRL_W], addr[1:0]};

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_irq_next   = r_irq_flag;
    w_en_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_en) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_next = r_preset;
        w_state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_next = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_next = r_count - 32'd1;
        end else begin
          // A preset of 0 lands here too, so it expires like a preset of 1.
          w_count_next = 32'd0;
          w_irq_next   = 1'b1;
          w_state_next = ST_INT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        if (w_mode == MODE_RELOAD) w_irq_next = 1'b0;
        else                       w_en_clr   = 1'b1;
      end
    endcase
    if (w_ctrl_wr) w_irq_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
      r_ctrl     <= '0;
      r_preset   <= 32'd0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_irq_flag <= w_irq_next;
      // A bus write to CTRL overrides the automatic EN clear of a one-shot expiry.
      if (w_ctrl_wr)     r_ctrl          <= w_ctrl_merged[CTRL_W-1:0];
      else if (w_en_clr) r_ctrl[CTRL_EN] <= 1'b0;
      if (w_preset_wr)   r_preset        <= lane_merge(r_preset, wdata, byteen);
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_sel) begin
      case (w_idx)
        IDX_CTRL:   w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
        IDX_PRESET: w_rdata = r_preset;
        IDX_COUNT:  w_rdata = r_count;
        default:    w_rdata = 32'd0;
      endcase
    end
  end

  assign rdata = w_rdata;
  assign irq   = r_irq_flag & r_ctrl[CTRL_IM];

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped countdown timer that responds to the CPU data-memory interface (address, write data, byte enables, read data).
- Drives one interrupt line into one bit of the CPU's HWInt vector.
- Sits on the system bridge beside data memory and is selected by address window.
- Provides one-shot and auto-reload modes, and a readable live count.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base of the 16-byte register window; only bits [31:4] are compared.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- addr  input  32  bus byte address (CPU m_data_addr)
- byteen  input  4  bus byte enables; nonzero means write (CPU m_data_byteen)
- wdata  input  32  bus write data, already lane-aligned (CPU m_data_wdata)
- rdata  output  32  bus read data, combinational
- irq  output  1  interrupt request to HWInt

Behaviour:
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]).
- Register index from addr[3:2]:
  - 0: CTRL, read/write. Bit[0] EN; bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00); bit[3] IM (interrupt mask, 1 = enabled); bits[31:4] read 0.
  - 1: PRESET, read/write, 32 bits.
  - 2: COUNT, read-only.
  - 3: reserved, reads 0.
- Reads:
  - rdata is combinational from addr; zero latency, so the M-stage load sees data in the same cycle.
  - rdata = 0 when !sel.
- Writes:
  - On the rising edge when sel && byteen != 0, merge each byte lane i where byteen[i]=1.
  - Writes to COUNT and to the reserved index are ignored and have no side effects.
  - Any CTRL write clears irq_flag.
- Reset: asynchronous. CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0 and rdata reflects zeroed registers immediately. A reset in any state aborts the count with no pending interrupt.
- FSM, states IDLE, LOAD, CNT, INT; every transition occurs on the rising edge:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE with COUNT held. Else if COUNT > 1, COUNT <= COUNT-1. Else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 00 or 1x: EN <= 0; go to IDLE; irq_flag held.
  - INT, MODE 01: irq_flag <= 0 (one-cycle pulse); go to IDLE, then reload through LOAD.
- Timing, with EN written at edge 0:
  - LOAD after edge 1.
  - COUNT = PRESET after edge 2.
  - INT and irq_flag after edge PRESET+2 for PRESET ≥ 1. PRESET = 0 behaves as PRESET = 1.
  - Auto-reload period is PRESET+3 cycles.
- irq = irq_flag & CTRL.IM, combinational.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the INT-state EN clear: the bus write wins for all CTRL bits.
  - A PRESET write during CNT does not affect the running COUNT; it takes effect at the next LOAD.
  - A CTRL write with EN=0 during CNT goes to IDLE on the next edge.
- Widths: COUNT arithmetic is 32-bit unsigned; no wrap below 0.

Decomposition:
- Shared constants file, extending the existing constants include:
  - register offsets (CTRL 0x0, PRESET 0x4, COUNT 0x8)
  - CTRL bit positions
  - MODE codes
  - FSM state encodings (2 bits)
  - default timer base address
- No sub-module. The byte-lane merge is a local function used for both CTRL and PRESET.

Test Plan:
- Reset mid-count: with COUNT=5 in CNT, assert reset asynchronously between edges → irq=0, read of 0x7F08 = 0, and the FSM stays IDLE after release.
- One-shot: write PRESET=3 to 0x7F04, then CTRL=0x9 (EN, MODE=00, IM) at edge 0 → COUNT reads 3, 2, 1, 0 after edges 2–5. irq=1 from edge 5 onward, CTRL reads 0x8 after edge 6, irq stays 1 until CTRL is written, and 0 after that write.
- Auto-reload: PRESET=2, CTRL=0xB → irq pulses high for exactly one cycle after edges 4, 9, 14 (period 5).
- Masking and byte enables:
  - CTRL=0x1 (IM=0), PRESET=1 → irq never asserts, but COUNT reaches 0 and EN clears.
  - PRESET write with byteen=4'b0010, wdata=0x0000AB00 over 0x11223344 → PRESET reads 0x1122AB44.
- Ignored and out-of-window accesses:
  - Write 0xFFFFFFFF to COUNT (0x7F08) during CNT → the count sequence is unaffected.
  - Access to 0x7F0C → reads 0, no side effects.
  - addr=0x7F10 → rdata=0 and no register changes.
- Collision: write CTRL=0x9 in the same cycle the FSM sits in INT (one-shot) → EN reads 1 afterwards, irq_flag is cleared, and a new countdown starts via LOAD.
